dec_bist_fault: RTL and testbench
=================================

DEC_BIST_FAULT -- requirements
Module: dec_bist_fault

Interface
REQ-001 Parameter: N, default 4, decoder select width; output width is 2**N (N from 2 to 6).
REQ-002 Clocking: one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 en  in  1  functional decode enable.
REQ-004 A  in  N  functional select code.
REQ-005 D  out  2**N  registered decoded output, one-hot when fault-free.
REQ-006 flt_we  in  1  fault-table write strobe.
REQ-007 flt_idx  in  N  output bit index the fault write targets.
REQ-008 flt_set  in  1  1 installs a fault, 0 removes it.
REQ-009 flt_val  in  1  stuck-at value; 0 = stuck-at-0, 1 = stuck-at-1.
REQ-010 flt_clr_all  in  1  clears every fault in one cycle.
REQ-011 bist_start  in  1  self-test request pulse.
REQ-012 bist_busy  out  1  high while self-test runs.
REQ-013 bist_done  out  1  one-cycle pulse at self-test end.
REQ-014 bist_pass  out  1  1 if no code mismatched; held until next start.
REQ-015 bist_fail_idx  out  N  first mismatching code; 0 if none.
REQ-016 bist_fail_cnt  out  N+1  number of mismatching codes.

Function
REQ-017 Fault application: raw = onehot(code); faulty[i] = mask[i] ? val[i] : raw[i].
REQ-018 Functional decode: with en=1 and not busy, D takes faulty(onehot(A)) at the next edge (latency 1); with en=0, D holds.
REQ-019 Fault write: flt_we sets mask[flt_idx]=flt_set and val[flt_idx]=flt_val at the edge; the new entry affects decodes sampled on later edges only.
REQ-020 flt_clr_all zeroes mask and val; it wins over a same-cycle flt_we.
REQ-021 flt_we and flt_clr_all are ignored while bist_busy=1.
REQ-022 FSM states: IDLE, RUN, CHECK, DONE.
REQ-023 IDLE->RUN on bist_start=1; counter cnt=0; bist_pass, bist_fail_idx and bist_fail_cnt clear to 0; bist_busy=1 from the next cycle.
REQ-024 RUN: each cycle drives the internal code cnt through the fault path into D, then increments cnt; the external en and A are ignored.
REQ-025 Compare pipeline: in RUN with cnt>0, and in CHECK, D is compared with onehot(previous code).
REQ-026 On a mismatch: bist_fail_cnt increments; bist_fail_idx captures the code only on the first mismatch.
REQ-027 RUN->CHECK after code 2**N-1 is driven; cnt wraps to 0 without overflow.
REQ-028 CHECK->DONE after one cycle; DONE->IDLE after one cycle.
REQ-029 In DONE: bist_done=1, bist_busy=0, bist_pass=(bist_fail_cnt==0).
REQ-030 Timing: bist_done is high exactly 2**N+2 cycles after the edge that sampled bist_start.
REQ-031 bist_start is ignored when not in IDLE.
REQ-032 After BIST, D holds the last test code's value until the next functional decode.

Reset
REQ-033 rst=1 at any edge, including mid-BIST, forces: state IDLE, cnt 0, D 0, mask 0, val 0, all bist outputs 0.
REQ-034 rst overrides every same-cycle input.

Structure
REQ-035 Package dec_pkg holds the FSM state enum and the stuck-at value constants SA0=0 and SA1=1.
REQ-036 A sub-module dec_nx2n (combinational, parameter N, N-to-2**N one-hot decoder) is instantiated once and fed by a mux of A and cnt.
REQ-037 Mask and val are 2**N-bit registers; no memory macro.

Verification
REQ-038 N=4, no faults, en=1, A=9 -> next cycle D=16'h0200; en=0 with A=3 -> D stays 16'h0200.
REQ-039 N=4, install SA0 on bit 0, then BIST -> bist_done 18 cycles after start; pass=0, fail_idx=0, fail_cnt=1.
REQ-040 N=4, install SA1 on bit 5, then BIST -> pass=0, fail_idx=0, fail_cnt=15; functional A=5 -> D=16'h0020.
REQ-041 flt_we and flt_clr_all in the same cycle, then BIST -> pass=1, fail_cnt=0; flt_we during busy -> no effect on a later BIST.
REQ-042 rst asserted on cycle 8 of a BIST -> next cycle busy=0, D=0, mask cleared; a fresh BIST gives pass=1.
REQ-043 bist_start held high for 30 cycles -> exactly one BIST run completes before the restart sampled in IDLE.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and constants for the fault-injectable decoder with built-in self-test.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SA0 = 1'b0;
    localparam logic SA1 = 1'b1;

endpackage

// File: rtl/dec_nx2n.sv
// Combinational N-to-2**N one-hot decoder.
module dec_nx2n #(
    parameter int N = 4
) (
    input  logic [N-1:0]      sel,
    output logic [(1<<N)-1:0] y
);

    // One-hot expansion of the select code
    always_comb begin
        y      = '0;
        y[sel] = 1'b1;
    end

endmodule

// File: rtl/dec_bist_fault.sv
// Registered N-to-2**N decoder with a per-bit stuck-at fault table and a
// self-test sequencer that sweeps every code through the faulty path.
module dec_bist_fault
    import dec_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N-1:0]        A,
    output logic [(1<<N)-1:0]   D,
    input  logic                flt_we,
    input  logic [N-1:0]        flt_idx,
    input  logic                flt_set,
    input  logic                flt_val,
    input  logic                flt_clr_all,
    input  logic                bist_start,
    output logic                bist_busy,
    output logic                bist_done,
    output logic                bist_pass,
    output logic [N-1:0]        bist_fail_idx,
    output logic [N:0]          bist_fail_cnt
);

    localparam int W = 1 << N;
    localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   ONE_N1 = {{N{1'b0}}, 1'b1};

    function automatic logic [W-1:0] onehot_f(input logic [N-1:0] c);
        logic [W-1:0] base_v;
        base_v   = {{(W-1){1'b0}}, 1'b1};
        onehot_f = base_v << c;
    endfunction

    state_t         state_r;
    logic [N-1:0]   cnt_r;
    logic [W-1:0]   mask_r;
    logic [W-1:0]   val_r;
    logic [W-1:0]   d_r;
    logic           busy_r;
    logic           done_r;
    logic           pass_r;
    logic [N-1:0]   fidx_r;
    logic [N:0]     fcnt_r;

    logic [N-1:0]   code_s;
    logic [W-1:0]   raw_s;
    logic [W-1:0]   faulty_s;
    logic [N-1:0]   prev_s;
    logic           cmp_en_s;
    logic [N:0]     fcnt_next_s;
    logic [N-1:0]   fidx_next_s;

    dec_nx2n #(.N(N)) u_dec (
        .sel (code_s),
        .y   (raw_s)
    );

    // Code source select, fault overlay and self-test comparison
    always_comb begin
        if (state_r == RUN) begin
            code_s = cnt_r;
        end else begin
            code_s = A;
        end
        faulty_s = (raw_s & ~mask_r) | (val_r & mask_r);
        // D always lags the driven code by one edge; cnt wraps so prev of 0 is the last code
        prev_s   = cnt_r - ONE_N;
        cmp_en_s = ((state_r == RUN) && (cnt_r != '0)) || (state_r == CHECK);
        if (cmp_en_s && (d_r != onehot_f(prev_s))) begin
            fcnt_next_s = fcnt_r + ONE_N1;
            if (fcnt_r == '0) begin
                fidx_next_s = prev_s;
            end else begin
                fidx_next_s = fidx_r;
            end
        end else begin
            fcnt_next_s = fcnt_r;
            fidx_next_s = fidx_r;
        end
    end

    // Fault table; frozen while the self-test is running
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
            val_r  <= '0;
        end else if (!busy_r) begin
            if (flt_clr_all) begin
                mask_r <= '0;
                val_r  <= '0;
            end else if (flt_we) begin
                mask_r[flt_idx] <= flt_set;
                val_r[flt_idx]  <= flt_val;
            end else begin
                mask_r <= mask_r;
                val_r  <= val_r;
            end
        end else begin
            mask_r <= mask_r;
            val_r  <= val_r;
        end
    end

    // Self-test sequencer, functional decode register and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            d_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            fidx_r  <= '0;
            fcnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (en) begin
                        d_r <= faulty_s;
                    end
                    if (bist_start) begin
                        state_r <= RUN;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        pass_r  <= 1'b0;
                        fidx_r  <= '0;
                        fcnt_r  <= '0;
                    end
                end
                RUN: begin
                    d_r    <= faulty_s;
                    cnt_r  <= cnt_r + ONE_N;
                    fcnt_r <= fcnt_next_s;
                    fidx_r <= fidx_next_s;
                    if (cnt_r == {N{1'b1}}) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    fcnt_r  <= fcnt_next_s;
                    fidx_r  <= fidx_next_s;
                    pass_r  <= (fcnt_next_s == '0);
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                    if (en) begin
                        d_r <= faulty_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign D             = d_r;
    assign bist_busy     = busy_r;
    assign bist_done     = done_r;
    assign bist_pass     = pass_r;
    assign bist_fail_idx = fidx_r;
    assign bist_fail_cnt = fcnt_r;

endmodule

// File: tb/tb_dec_bist_fault.sv
// Scoreboard bench for dec_bist_fault (N=4): self-test results are queued at
// start and checked by a monitor when bist_done pulses.
module tb_dec_bist_fault;
    import dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  A = 4'd0;
    logic [15:0] D;
    logic        flt_we = 1'b0;
    logic [3:0]  flt_idx = 4'd0;
    logic        flt_set = 1'b0;
    logic        flt_val = 1'b0;
    logic        flt_clr_all = 1'b0;
    logic        bist_start = 1'b0;
    logic        bist_busy;
    logic        bist_done;
    logic        bist_pass;
    logic [3:0]  bist_fail_idx;
    logic [4:0]  bist_fail_cnt;

    typedef struct {
        logic       pass;
        logic [3:0] idx;
        logic [4:0] cnt;
        int         done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t0;
    int   done_seen;
    logic busy_e18;
    logic busy_e19;

    dec_bist_fault #(.N(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .A             (A),
        .D             (D),
        .flt_we        (flt_we),
        .flt_idx       (flt_idx),
        .flt_set       (flt_set),
        .flt_val       (flt_val),
        .flt_clr_all   (flt_clr_all),
        .bist_start    (bist_start),
        .bist_busy     (bist_busy),
        .bist_done     (bist_done),
        .bist_pass     (bist_pass),
        .bist_fail_idx (bist_fail_idx),
        .bist_fail_cnt (bist_fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every bist_done pulse is matched against the oldest queued result
    always @(negedge clk) begin
        if (!rst && bist_done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("bist_pass", {31'd0, bist_pass}, {31'd0, mon_e.pass});
                check("bist_fail_idx", {28'd0, bist_fail_idx}, {28'd0, mon_e.idx});
                check("bist_fail_cnt", {27'd0, bist_fail_cnt}, {27'd0, mon_e.cnt});
                check("bist_done_cycle", cyc, mon_e.done_cyc);
            end
        end
    end

    task automatic fault_write(input logic [3:0] idx, input logic set, input logic val);
        flt_we  = 1'b1;
        flt_idx = idx;
        flt_set = set;
        flt_val = val;
        tick();
        flt_we  = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        check("bist_outstanding", q.size(), 32'd0);
        tick();
    endtask

    task automatic bist_run(input logic pass, input logic [3:0] idx, input logic [4:0] cnt);
        bist_start = 1'b1;
        q.push_back('{pass, idx, cnt, cyc + 18});
        tick();
        bist_start = 1'b0;
        wait_empty();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_D", {16'd0, D}, 32'h0);
        check("reset_busy", {31'd0, bist_busy}, 32'd0);
        check("reset_done", {31'd0, bist_done}, 32'd0);
        check("reset_pass", {31'd0, bist_pass}, 32'd0);
        check("reset_fcnt", {27'd0, bist_fail_cnt}, 32'd0);

        // Functional decode and hold
        en = 1'b1; A = 4'd9;
        tick();
        check("dec_A9", {16'd0, D}, 32'h0200);
        en = 1'b0; A = 4'd3;
        tick();
        tick();
        check("hold_en0", {16'd0, D}, 32'h0200);

        // Stuck-at-0 on bit 0: only code 0 mismatches
        fault_write(4'd0, 1'b1, SA0);
        bist_run(1'b0, 4'd0, 5'd1);
        check("post_bist_D_sa0", {16'd0, D}, 32'h8000);

        // Remove it, install stuck-at-1 on bit 5: all codes but 5 mismatch
        fault_write(4'd0, 1'b0, SA0);
        fault_write(4'd5, 1'b1, SA1);
        bist_run(1'b0, 4'd0, 5'd15);
        check("post_bist_D_sa1", {16'd0, D}, 32'h8020);
        en = 1'b1; A = 4'd5;
        tick();
        check("dec_A5_sa1", {16'd0, D}, 32'h0020);
        A = 4'd0;
        tick();
        check("dec_A0_sa1", {16'd0, D}, 32'h0021);
        en = 1'b0;

        // Clear-all wins over a simultaneous write
        flt_clr_all = 1'b1;
        fault_write(4'd3, 1'b1, SA0);
        flt_clr_all = 1'b0;
        bist_run(1'b1, 4'd0, 5'd0);

        // Fault write during busy is ignored
        bist_start = 1'b1;
        q.push_back('{1'b1, 4'd0, 5'd0, cyc + 18});
        tick();
        bist_start = 1'b0;
        tick();
        tick();
        check("busy_mid_run", {31'd0, bist_busy}, 32'd1);
        fault_write(4'd2, 1'b1, SA1);
        wait_empty();
        bist_run(1'b1, 4'd0, 5'd0);

        // Reset on cycle 8 of a run aborts it and clears the fault table
        fault_write(4'd7, 1'b1, SA0);
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, bist_busy}, 32'd0);
        check("rst_mid_D", {16'd0, D}, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        bist_run(1'b1, 4'd0, 5'd0);

        // bist_start held for 30 cycles: one completed run, restart sampled in IDLE
        t0 = cyc;
        bist_start = 1'b1;
        q.push_back('{1'b1, 4'd0, 5'd0, t0 + 18});
        q.push_back('{1'b1, 4'd0, 5'd0, t0 + 37});
        done_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bist_done) done_seen++;
            if (i == 19) busy_e18 = bist_busy;
            if (i == 20) busy_e19 = bist_busy;
        end
        bist_start = 1'b0;
        check("held_start_done_count", done_seen, 32'd1);
        check("held_start_idle_gap", {31'd0, busy_e18}, 32'd0);
        check("held_start_restart", {31'd0, busy_e19}, 32'd1);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
